// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: button pulses, running time and alarm status between the wall clock and the alarm scheduler.
interface alarm_ctrl_if;
  logic tick_1hz, up_pulse, down_pulse, center_pulse, mode_pulse;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic [4:0] al_hour;
  logic [5:0] al_min;
  logic armed, ringing, snoozing, show_alarm, buzzer;
  logic [1:0] edit_field;
  modport master (
    output tick_1hz, up_pulse, down_pulse, center_pulse, mode_pulse, cur_hour, cur_min, cur_sec,
    input al_hour, al_min, armed, ringing, snoozing, show_alarm, edit_field, buzzer
  );
  modport slave (
    input tick_1hz, up_pulse, down_pulse, center_pulse, mode_pulse, cur_hour, cur_min, cur_sec,
    output al_hour, al_min, armed, ringing, snoozing, show_alarm, edit_field, buzzer
  );
endinterface

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm set-point editing, match detection, ring/snooze sequencing and buzzer gating.
// Define ALARM_SNOOZE_EN to build the SNOOZE state and its counter.
module alarm_ctrl #(
  parameter int RST_HOUR    = 6,
  parameter int RST_MIN     = 0,
  parameter int SET_TIMEOUT = 30,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int BUZZ_HALF   = 25000
) (
  input logic clk,
  input logic rst_n,
  alarm_ctrl_if.slave bus
);
  localparam int IW = $clog2(SET_TIMEOUT) + 1;
  localparam int RW = $clog2(RING_SECS) + 1;
  localparam int DW = $clog2(BUZZ_HALF) + 1;
`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_SECS) + 1;
  typedef enum logic [2:0] {NORMAL, SET_H, SET_M, RING, SNOOZE} state_t;
  logic [SW-1:0] snz_cnt;
  logic snz_done;
  assign snz_done = bus.tick_1hz & (snz_cnt == SW'(SNOOZE_SECS - 1));
`else
  typedef enum logic [2:0] {NORMAL, SET_H, SET_M, RING} state_t;
  assign bus.snoozing = 1'b0;
`endif
  state_t state;
  logic [IW-1:0] idle_cnt;
  logic [RW-1:0] ring_cnt;
  logic [DW-1:0] div;
  logic tone, gate, match_q, match, trig, c, m, u, d, any_btn, editing, idle_done, ring_done;
  // Decode to a single winning button: center > mode > up > down.
  assign c = bus.center_pulse;
  assign m = bus.mode_pulse & ~c;
  assign u = bus.up_pulse & ~c & ~bus.mode_pulse;
  assign d = bus.down_pulse & ~c & ~bus.mode_pulse & ~bus.up_pulse;
  assign any_btn = bus.center_pulse | bus.mode_pulse | bus.up_pulse | bus.down_pulse;
  assign editing = (state == SET_H) || (state == SET_M);
  assign match = bus.armed & (bus.cur_hour == bus.al_hour) & (bus.cur_min == bus.al_min) & (bus.cur_sec == 6'd0);
  assign trig = match & ~match_q;
  assign idle_done = bus.tick_1hz & ~any_btn & (idle_cnt == IW'(SET_TIMEOUT - 1));
  assign ring_done = bus.tick_1hz & (ring_cnt == RW'(RING_SECS - 1));
  assign bus.buzzer = tone & gate & bus.ringing;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= NORMAL;
      bus.al_hour <= 5'(RST_HOUR);
      bus.al_min <= 6'(RST_MIN);
      bus.armed <= 1'b0;
      bus.ringing <= 1'b0;
      bus.show_alarm <= 1'b0;
      bus.edit_field <= 2'b00;
      match_q <= 1'b0;
      idle_cnt <= '0;
      ring_cnt <= '0;
      div <= '0;
      tone <= 1'b0;
      gate <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt <= '0;
      bus.snoozing <= 1'b0;
`endif
    end else begin
      match_q <= match;
      idle_cnt <= (!editing || any_btn) ? '0 : idle_cnt + IW'(bus.tick_1hz && idle_cnt != IW'(SET_TIMEOUT));
      ring_cnt <= (state != RING) ? '0 : ring_cnt + RW'(bus.tick_1hz && ring_cnt != RW'(RING_SECS));
      // Tone, divider and gate rest in their entry values whenever not ringing.
      div <= (state != RING || div == DW'(BUZZ_HALF - 1)) ? '0 : div + DW'(1);
      tone <= (state == RING) & (tone ^ (div == DW'(BUZZ_HALF - 1)));
      gate <= (state != RING) | (gate ^ bus.tick_1hz);
`ifdef ALARM_SNOOZE_EN
      snz_cnt <= (state != SNOOZE) ? '0 : snz_cnt + SW'(bus.tick_1hz && snz_cnt != SW'(SNOOZE_SECS));
`endif
      case (state)
        NORMAL:
          if (trig) begin
            state <= RING;
            bus.ringing <= 1'b1;
          end else if (c) bus.armed <= ~bus.armed;
          else if (m) begin
            state <= SET_H;
            bus.show_alarm <= 1'b1;
            bus.edit_field <= 2'b01;
          end
        SET_H:
          if (c) begin
            state <= SET_M;
            bus.edit_field <= 2'b10;
          end else if (m || idle_done) begin
            state <= NORMAL;
            bus.show_alarm <= 1'b0;
            bus.edit_field <= 2'b00;
          end else if (u) bus.al_hour <= (bus.al_hour == 5'd23) ? 5'd0 : bus.al_hour + 5'd1;
          else if (d) bus.al_hour <= (bus.al_hour == 5'd0) ? 5'd23 : bus.al_hour - 5'd1;
        SET_M:
          if (c || m || idle_done) begin
            state <= NORMAL;
            bus.armed <= bus.armed | c;
            bus.show_alarm <= 1'b0;
            bus.edit_field <= 2'b00;
          end else if (u) bus.al_min <= (bus.al_min == 6'd59) ? 6'd0 : bus.al_min + 6'd1;
          else if (d) bus.al_min <= (bus.al_min == 6'd0) ? 6'd59 : bus.al_min - 6'd1;
        RING:
          if (c) begin
            state <= NORMAL;
            bus.ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (u || d) begin
            state <= SNOOZE;
            bus.ringing <= 1'b0;
            bus.snoozing <= 1'b1;
`endif
          end else if (ring_done) begin
            state <= NORMAL;
            bus.ringing <= 1'b0;
          end
`ifdef ALARM_SNOOZE_EN
        SNOOZE:
          if (c) begin
            state <= NORMAL;
            bus.snoozing <= 1'b0;
          end else if (snz_done) begin
            state <= RING;
            bus.snoozing <= 1'b0;
            bus.ringing <= 1'b1;
          end
`endif
        default: state <= NORMAL;
      endcase
    end
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed test-plan steps plus random stimulus, every cycle checked against a behavioural alarm model.
module tb_alarm_ctrl;
  localparam int RS = 4, SS = 3, TO = 5, BH = 4;
  localparam int NRM = 0, SH = 1, SM = 2, RG = 3, SZ = 4;
  localparam logic [4:0] B_C = 5'b10000, B_M = 5'b01000, B_U = 5'b00100, B_D = 5'b00010, B_T = 5'b00001, B_0 = 5'b00000;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  alarm_ctrl_if bus();
  alarm_ctrl #(.RST_HOUR(6), .RST_MIN(0), .SET_TIMEOUT(TO), .RING_SECS(RS), .SNOOZE_SECS(SS), .BUZZ_HALF(BH))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int th, tm, ts;
  int mst, mh, mm, midle, mrt, mrc, msc;
  bit marm, mq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    mst = NRM; mh = 6; mm = 0; marm = 0; mq = 0; midle = 0; mrt = 0; mrc = 0; msc = 0;
  endtask

  // Reference behaviour: one call per clock edge with the inputs seen at that edge.
  task automatic model_step(input logic [4:0] b);
    bit match, trig, any;
    int btn;
    match = marm && th == mh && tm == mm && ts == 0;
    trig = match && !mq;
    mq = match;
    any = |b[4:1];
    btn = b[4] ? 4 : b[3] ? 3 : b[2] ? 2 : b[1] ? 1 : 0;
    if (mst == RG) mrc++;
    if (mst == SH || mst == SM) begin
      if (any) midle = 0;
      else if (b[0]) midle++;
    end
    case (mst)
      NRM: if (trig) begin mst = RG; mrc = 0; mrt = 0; end
           else if (btn == 4) marm = !marm;
           else if (btn == 3) begin mst = SH; midle = 0; end
      SH:  if (btn == 4) mst = SM;
           else if (btn == 3) mst = NRM;
           else if (btn == 2) mh = (mh + 1) % 24;
           else if (btn == 1) mh = (mh + 23) % 24;
           else if (midle >= TO) mst = NRM;
      SM:  if (btn == 4) begin mst = NRM; marm = 1; end
           else if (btn == 3) mst = NRM;
           else if (btn == 2) mm = (mm + 1) % 60;
           else if (btn == 1) mm = (mm + 59) % 60;
           else if (midle >= TO) mst = NRM;
      RG:  if (btn == 4) mst = NRM;
           else if (SNZ && (btn == 2 || btn == 1)) begin mst = SZ; msc = 0; end
           else if (b[0]) begin mrt++; if (mrt >= RS) mst = NRM; end
      SZ:  if (btn == 4) mst = NRM;
           else if (b[0]) begin msc++; if (msc >= SS) begin mst = RG; mrt = 0; mrc = 0; end end
      default: mst = NRM;
    endcase
  endtask

  task automatic compare_all();
    chk("al_hour", bus.al_hour, mh);
    chk("al_min", bus.al_min, mm);
    chk("armed", bus.armed, marm);
    chk("ringing", bus.ringing, mst == RG);
    chk("snoozing", bus.snoozing, mst == SZ);
    chk("show_alarm", bus.show_alarm, mst == SH || mst == SM);
    chk("edit_field", bus.edit_field, mst == SH ? 1 : mst == SM ? 2 : 0);
    chk("buzzer", bus.buzzer, mst == RG && (mrc / BH) % 2 == 1 && mrt % 2 == 0);
  endtask

  task automatic cyc(input logic [4:0] b);
    @(negedge clk);
    bus.center_pulse = b[4];
    bus.mode_pulse = b[3];
    bus.up_pulse = b[2];
    bus.down_pulse = b[1];
    bus.tick_1hz = b[0];
    bus.cur_hour = 5'(th);
    bus.cur_min = 6'(tm);
    bus.cur_sec = 6'(ts);
    @(posedge clk);
    model_step(b);
    #1 compare_all();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_al_hour"}, bus.al_hour, 6);
    chk({tag, "_al_min"}, bus.al_min, 0);
    chk({tag, "_armed"}, bus.armed, 0);
    chk({tag, "_ringing"}, bus.ringing, 0);
    chk({tag, "_snoozing"}, bus.snoozing, 0);
    chk({tag, "_show"}, bus.show_alarm, 0);
    chk({tag, "_edit"}, bus.edit_field, 0);
    chk({tag, "_buzzer"}, bus.buzzer, 0);
  endtask

  initial begin
    th = 12; tm = 0; ts = 30;
    {bus.center_pulse, bus.mode_pulse, bus.up_pulse, bus.down_pulse, bus.tick_1hz} = 5'b0;
    bus.cur_hour = 5'(th); bus.cur_min = 6'(tm); bus.cur_sec = 6'(ts);
    m_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset("rst");
    @(negedge clk) rst_n = 1'b1;
    // Edit sequence to 09:59 and arm.
    cyc(B_M); chk("seth_edit", bus.edit_field, 1);
    repeat (3) cyc(B_U);
    cyc(B_C); chk("setm_edit", bus.edit_field, 2);
    cyc(B_D); chk("min_wrap_down", bus.al_min, 59);
    cyc(B_C);
    chk("seq_hour", bus.al_hour, 9); chk("seq_min", bus.al_min, 59);
    chk("seq_armed", bus.armed, 1); chk("seq_edit", bus.edit_field, 0);
    // Wrap boundaries and same-cycle up+down.
    cyc(B_M); repeat (14) cyc(B_U); chk("hour23", bus.al_hour, 23);
    cyc(B_U); chk("hour_wrap_up", bus.al_hour, 0);
    cyc(B_C); cyc(B_U); chk("min_wrap_up", bus.al_min, 0);
    cyc(B_D); chk("min_wrap_dn", bus.al_min, 59);
    cyc(B_U | B_D); chk("up_over_down", bus.al_min, 0);
    cyc(B_C);
    // Set 07:30 and trigger.
    cyc(B_M); repeat (7) cyc(B_U); cyc(B_C); repeat (30) cyc(B_U); cyc(B_C);
    chk("al_0730", {bus.al_hour, bus.al_min}, {5'd7, 6'd30});
    th = 7; tm = 29; ts = 59; cyc(B_0); chk("pre_match", bus.ringing, 0);
    tm = 30; ts = 0; cyc(B_0); chk("ring_on", bus.ringing, 1); chk("buzz_k0", bus.buzzer, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc(B_0);
      chk("buzz_tone", bus.buzzer, (k / 4) % 2);
    end
    cyc(B_T);
    for (int k = 0; k < 8; k++) begin
      chk("buzz_gated", bus.buzzer, 0);
      cyc(B_0);
    end
    cyc(B_T); cyc(B_T); chk("ring_3ticks", bus.ringing, 1);
    cyc(B_T); chk("ring_auto_stop", bus.ringing, 0); chk("ring_armed", bus.armed, 1);
    repeat (3) cyc(B_0);
    chk("no_retrigger", bus.ringing, 0);
    // Snooze.
    tm = 29; ts = 59; cyc(B_0);
    tm = 30; ts = 0; cyc(B_0); chk("ring2_on", bus.ringing, 1);
    repeat (5) cyc(B_0); chk("buzz_before_up", bus.buzzer, 1);
    cyc(B_U);
`ifdef ALARM_SNOOZE_EN
    chk("snooze_on", bus.snoozing, 1); chk("snooze_buzz", bus.buzzer, 0); chk("snooze_ring", bus.ringing, 0);
    cyc(B_T); cyc(B_T); chk("snooze_hold", bus.snoozing, 1);
    cyc(B_T); chk("resnooze_ring", bus.ringing, 1); chk("resnooze_snz", bus.snoozing, 0);
`else
    chk("up_keeps_ring", bus.ringing, 1); chk("no_snooze", bus.snoozing, 0);
`endif
    cyc(B_C); chk("dismiss", bus.ringing, 0);
    // Asynchronous reset in the middle of a ring.
    tm = 29; ts = 59; cyc(B_0);
    tm = 30; ts = 0; cyc(B_0);
    repeat (5) cyc(B_0); chk("buzz_before_rst", bus.buzzer, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    m_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    // Edit timeout with an intervening press.
    cyc(B_M); repeat (4) cyc(B_T); cyc(B_U); repeat (4) cyc(B_T);
    chk("timeout_hold", bus.edit_field, 1);
    cyc(B_T); chk("timeout_exit", bus.edit_field, 0); chk("timeout_keep", bus.al_hour, 7);
    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] b;
      if ($urandom_range(7) == 0) begin
        if ($urandom_range(2) == 0) begin th = mh; tm = mm; ts = $urandom_range(1); end
        else begin th = $urandom_range(23); tm = $urandom_range(59); ts = $urandom_range(59); end
      end
      b[4] = $urandom_range(15) == 0;
      b[3] = $urandom_range(15) == 0;
      b[2] = $urandom_range(7) == 0;
      b[1] = $urandom_range(7) == 0;
      b[0] = $urandom_range(3) == 0;
      cyc(b);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm scheduler for the wall clock. It holds the alarm set-point and sequences alarm editing from the debounced push-button pulses. It compares the running time from the seconds/minutes/hours counters against the set-point, and drives ringing, snooze and buzzer outputs. It sits beside the time-setting FSM and feeds the display mux and the buzzer pin.

## Interface
Parameters:
- `RST_HOUR`, 6: alarm hour after reset (0-23).
- `RST_MIN`, 0: alarm minute after reset (0-59).
- `SET_TIMEOUT`, 30: `tick_1hz` pulses without a button press before edit mode is abandoned.
- `RING_SECS`, 60: ring duration in seconds before auto-stop.
- `SNOOZE_SECS`, 300: snooze duration in seconds.
- `BUZZ_HALF`, 25000: `clk` cycles per half-period of the buzzer tone.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tick_1hz` in 1: one-cycle pulse per second, coincident with the seconds counter update.
- `up_pulse`, `down_pulse`, `center_pulse`, `mode_pulse` in 1 each: debounced one-cycle press pulses.
- `cur_hour` in 5, `cur_min` in 6, `cur_sec` in 6: current time, binary.
- `al_hour` out 5, `al_min` out 6: alarm set-point.
- `armed` out 1: alarm enabled.
- `ringing` out 1: high in RING.
- `snoozing` out 1: high in SNOOZE.
- `show_alarm` out 1: display mux selects the set-point.
- `edit_field` out 2: 00 none, 01 hour, 10 minute.
- `buzzer` out 1: gated tone.

## Operation
- States: NORMAL, SET_H, SET_M, RING, SNOOZE. All outputs are registered.
- Button priority in one cycle: center > mode > up > down. Lower-priority pulses in the same cycle are ignored.
- NORMAL:
  - `mode_pulse` -> SET_H.
  - `center_pulse` toggles `armed`.
  - up/down are ignored.
- SET_H:
  - up increments `al_hour` (23 -> 0); down decrements it (0 -> 23).
  - center -> SET_M.
  - mode -> NORMAL; edits are kept and `armed` is unchanged.
- SET_M:
  - up/down step `al_min` modulo 60 (59 -> 0, 0 -> 59).
  - center -> NORMAL and sets `armed` = 1.
  - mode -> NORMAL.
- Edit timeout: in SET_H/SET_M an idle counter clears on any button pulse and increments on `tick_1hz`. Reaching `SET_TIMEOUT` -> NORMAL, edits kept.
- `show_alarm` = 1 in SET_H/SET_M, else 0. `edit_field` = 01 in SET_H, 10 in SET_M, else 00.
- Match:
  - `match` = `armed` & (`cur_hour` == `al_hour`) & (`cur_min` == `al_min`) & (`cur_sec` == 0).
  - The trigger is the rising edge of `match` (`match_q` is registered), so the alarm fires once per day.
  - The trigger is honoured only in NORMAL; a match during SET_H/SET_M is lost.
- RING:
  - The ring counter counts `tick_1hz`; reaching `RING_SECS` -> NORMAL with `armed` left at 1.
  - center -> NORMAL (dismiss), `armed` stays 1.
  - up or down -> SNOOZE.
  - mode is ignored.
- SNOOZE:
  - The snooze counter counts `tick_1hz`; reaching `SNOOZE_SECS` -> RING with the ring counter cleared.
  - center -> NORMAL (cancel).
  - up/down/mode are ignored.
- Buzzer:
  - A tone divider toggles `tone` every `BUZZ_HALF` clk cycles while in RING and is held at 0 otherwise.
  - A beep gate toggles on each `tick_1hz` in RING and resets to 1 on RING entry.
  - `buzzer` = `tone` & gate & `ringing`.
- Counter widths are sized by `$clog2` of their parameter plus 1. Counters saturate and never wrap.

## Timing
- Reset values:
  - State NORMAL; `al_hour` = `RST_HOUR`, `al_min` = `RST_MIN`.
  - `armed`, `ringing`, `snoozing`, `show_alarm`, `buzzer` = 0; `edit_field` = 00.
  - All counters and `match_q` = 0.
- A button pulse at cycle N updates the state/set-point outputs at N+1.
- `match` rises at cycle N -> `ringing` = 1 at N+1.
- A `tick_1hz` that completes a count produces the state change at the next edge.
- A reset assertion mid-ring drops `buzzer` and `ringing` asynchronously.
- A button pulse and a timeout-completing tick in the same cycle: the button wins and the idle counter clears.

## Configuration
- `ALARM_SNOOZE_EN` defined: SNOOZE state, snooze counter and `snoozing` logic are present as described.
- `ALARM_SNOOZE_EN` undefined:
  - No SNOOZE state; up/down in RING are ignored.
  - `snoozing` is tied to 0.
  - `SNOOZE_SECS` is unused.

## Test plan
- Reset, then mode, up ×3, center, down, center -> `al_hour` = 9, `al_min` = 59, `armed` = 1, back in NORMAL with `edit_field` = 00.
- `al_hour` = 23 and up in SET_H -> 0; `al_min` = 0 and down in SET_M -> 59; up+down in the same cycle -> up applied only.
- Armed 07:30, drive time 07:29:59 -> 07:30:00 -> `ringing` = 1 one cycle later. Hold 07:30:00 -> no retrigger. With `RING_SECS` = 4, after 4 ticks `ringing` = 0 and `armed` = 1.
- RING, up pulse -> `snoozing` = 1 and `buzzer` = 0. With `SNOOZE_SECS` = 3, after 3 ticks `ringing` = 1 again; center -> NORMAL. Without `ALARM_SNOOZE_EN`, up keeps RING.
- SET_H with `SET_TIMEOUT` = 5: 4 ticks, up, 4 ticks -> still SET_H; 1 more tick -> NORMAL with the edit retained.
- `BUZZ_HALF` = 4 in RING -> `buzzer` toggles every 4 cycles while the gate is 1 and is 0 while the gate is 0. `rst_n` low mid-ring -> all outputs return to reset values immediately.
